axi_wr_slv: RTL and testbench

Single-outstanding AXI4 write-channel responder (AW/W/B) with an internal byte-strobed word memory. It is the write-direction counterpart of the read path between `axi_mst` and `axi_slv`. It accepts one address burst, stores its data beats, and returns one write response. A registered debug read port lets the bench and later integration inspect memory contents.

---
 rtl/axi_wr_slv.sv | 210 +++++++++++++++++++++
 tb/tb_axi_wr_slv.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slv.sv
// Single-outstanding AXI4 write responder (AW/W/B) backed by a byte-strobed word memory,
// with a registered debug read port for inspecting memory contents.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_wr_slv #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [`AXI_ID_WIDTH-1:0]      axi_slv_awid,
    input  logic [`AXI_ADDR_WIDTH-1:0]    axi_slv_awaddr,
    input  logic [`AXI_LEN_WIDTH-1:0]     axi_slv_awlen,
    input  logic [`AXI_SIZE_WIDTH-1:0]    axi_slv_awsize,
    input  logic [`AXI_BURST_WIDTH-1:0]   axi_slv_awburst,
    input  logic                          axi_slv_awvalid,
    output logic                          axi_slv_awready,
    input  logic [`AXI_DATA_WIDTH-1:0]    axi_slv_wdata,
    input  logic [`AXI_DATA_WIDTH/8-1:0]  axi_slv_wstrb,
    input  logic                          axi_slv_wlast,
    input  logic                          axi_slv_wvalid,
    output logic                          axi_slv_wready,
    output logic [`AXI_ID_WIDTH-1:0]      axi_slv_bid,
    output logic [`AXI_RESP_WIDTH-1:0]    axi_slv_bresp,
    output logic                          axi_slv_bvalid,
    input  logic                          axi_slv_bready,
    input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
    output logic [`AXI_DATA_WIDTH-1:0]    dbg_rdata
);

    localparam int STRB  = `AXI_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(STRB);
    localparam int AW    = `AXI_ADDR_WIDTH;
    localparam int IW    = AW - LSB;
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] BRESP = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0]    MAX_SIZE   = 3'(LSB);
    localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] DEPTH_IDX  = IW'(MEM_DEPTH);
    localparam logic [1:0]    RESP_OKAY  = 2'b00;
    localparam logic [1:0]    RESP_SLV   = 2'b10;

    logic [1:0]                  state_r;
    logic [`AXI_ID_WIDTH-1:0]    id_r;
    logic [AW-1:0]               addr_r;
    logic [7:0]                  len_r;
    logic [2:0]                  size_r;
    logic [1:0]                  burst_r;
    logic [7:0]                  beat_cnt_r;
    logic                        err_r;
    logic [`AXI_DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                        aw_hs_s, w_hs_s, b_hs_s;
    logic [2:0]                  aw_size_s;
    logic [1:0]                  aw_burst_s;
    logic                        aw_err_s;
    logic [AW-1:0]               bytes_s, incr_s, wrap_mask_s, next_addr_s;
    logic [IW-1:0]               word_idx_s;
    logic                        in_range_s, last_beat_s, beat_err_s;

    assign axi_slv_awready = (state_r == IDLE);
    assign axi_slv_wready  = (state_r == WDATA);
    assign axi_slv_bvalid  = (state_r == BRESP);

    assign aw_hs_s = axi_slv_awready & axi_slv_awvalid;
    assign w_hs_s  = axi_slv_wready  & axi_slv_wvalid;
    assign b_hs_s  = axi_slv_bvalid  & axi_slv_bready;

    // Sanitize the incoming burst: illegal size/burst/wrap length degrade to legal beats plus an error.
    always_comb begin
        aw_err_s   = 1'b0;
        aw_size_s  = axi_slv_awsize;
        aw_burst_s = BURST_INCR;
        if (axi_slv_awsize > MAX_SIZE) begin
            aw_size_s = MAX_SIZE;
            aw_err_s  = 1'b1;
        end else begin
            aw_size_s = axi_slv_awsize;
        end
        case (axi_slv_awburst)
            BURST_FIXED: aw_burst_s = BURST_FIXED;
            BURST_INCR:  aw_burst_s = BURST_INCR;
            BURST_WRAP: begin
                if (axi_slv_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) begin
                    aw_burst_s = BURST_WRAP;
                end else begin
                    aw_burst_s = BURST_INCR;
                    aw_err_s   = 1'b1;
                end
            end
            default: begin
                aw_burst_s = BURST_INCR;
                aw_err_s   = 1'b1;
            end
        endcase
    end

    // Per-beat address arithmetic and error detection.
    always_comb begin
        bytes_s     = ADDR_ONE << size_r;
        incr_s      = addr_r + bytes_s;
        wrap_mask_s = (({{(AW-8){1'b0}}, len_r} + ADDR_ONE) << size_r) - ADDR_ONE;
        case (burst_r)
            BURST_FIXED: next_addr_s = addr_r;
            BURST_WRAP:  next_addr_s = (addr_r & ~wrap_mask_s) | (incr_s & wrap_mask_s);
            default:     next_addr_s = incr_s;
        endcase
        word_idx_s  = addr_r[AW-1:LSB];
        in_range_s  = (word_idx_s < DEPTH_IDX);
        last_beat_s = (beat_cnt_r == len_r);
        beat_err_s  = ~in_range_s | (axi_slv_wlast != last_beat_s);
    end

    // Transaction FSM with latched burst attributes and the response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            id_r          <= '0;
            addr_r        <= '0;
            len_r         <= 8'd0;
            size_r        <= 3'd0;
            burst_r       <= 2'b00;
            beat_cnt_r    <= 8'd0;
            err_r         <= 1'b0;
            axi_slv_bid   <= '0;
            axi_slv_bresp <= RESP_OKAY;
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        id_r       <= axi_slv_awid;
                        addr_r     <= axi_slv_awaddr;
                        len_r      <= axi_slv_awlen;
                        size_r     <= aw_size_s;
                        burst_r    <= aw_burst_s;
                        beat_cnt_r <= 8'd0;
                        err_r      <= aw_err_s;
                        state_r    <= WDATA;
                    end
                end
                WDATA: begin
                    if (w_hs_s) begin
                        addr_r     <= next_addr_s;
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        err_r      <= err_r | beat_err_s;
                        if (last_beat_s) begin
                            axi_slv_bid   <= id_r;
                            axi_slv_bresp <= (err_r | beat_err_s) ? RESP_SLV : RESP_OKAY;
                            state_r       <= BRESP;
                        end
                    end
                end
                BRESP: begin
                    if (b_hs_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Byte-strobed memory write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_hs_s && in_range_s) begin
            for (int i = 0; i < STRB; i++) begin
                if (axi_slv_wstrb[i]) begin
                    mem[word_idx_s[IDX_W-1:0]][8*i +: 8] <= axi_slv_wdata[8*i +: 8];
                end
            end
        end
    end

    // Debug read returns the pre-write word when it collides with a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata <= '0;
        end else begin
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_axi_wr_slv.sv
// Randomized self-checking bench for axi_wr_slv against a byte-level reference memory
// driven by the AXI write addressing and error rules.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_wr_slv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [`AXI_ID_WIDTH-1:0]   awid = '0;
    logic [`AXI_ADDR_WIDTH-1:0] awaddr = '0;
    logic [7:0]  awlen = 8'd0;
    logic [2:0]  awsize = 3'd0;
    logic [1:0]  awburst = 2'd0;
    logic        awvalid = 1'b0, awready;
    logic [`AXI_DATA_WIDTH-1:0] wdata = '0;
    logic [3:0]  wstrb = 4'd0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [`AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic [7:0]  dbg_addr = 8'd0;
    logic [`AXI_DATA_WIDTH-1:0] dbg_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [256];
    bit          ref_valid [256];
    logic [31:0] dq [256];
    logic [3:0]  sq [256];

    axi_wr_slv #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .axi_slv_awid(awid), .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen),
        .axi_slv_awsize(awsize), .axi_slv_awburst(awburst),
        .axi_slv_awvalid(awvalid), .axi_slv_awready(awready),
        .axi_slv_wdata(wdata), .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
        .axi_slv_wvalid(wvalid), .axi_slv_wready(wready),
        .axi_slv_bid(bid), .axi_slv_bresp(bresp),
        .axi_slv_bvalid(bvalid), .axi_slv_bready(bready),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_read(input int idx, output logic [31:0] val);
        @(negedge clk);
        dbg_addr = idx[7:0];
        @(negedge clk);
        val = dbg_rdata;
    endtask

    task automatic check_all_mem();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            dbg_read(i, v);
            if (ref_valid[i]) check("mem_dump", v, ref_mem[i]);
        end
    endtask

    // One burst: drives AW, W (data from dq/sq) and B, updating the reference memory per accepted beat.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                             input int gap_beat, input int gap_len, input int bdelay,
                             input int abort_after, output logic [1:0] resp_seen);
        logic [31:0] a, idx, oldw, cmask, bytes;
        int  eff_size, n, guard, cont;
        bit  is_fixed, is_wrap, err, aw_bad, old_ok;
        logic [1:0] exp_resp;
        resp_seen = 2'bxx;
        err = 1'b0;
        eff_size = int'(size);
        if (size > 3'd2) begin err = 1'b1; eff_size = 2; end
        bytes = 32'd1 << eff_size;
        is_fixed = (burst == 2'b00);
        is_wrap  = (burst == 2'b10);
        if (burst == 2'b11) err = 1'b1;
        if (is_wrap && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            err = 1'b1;
            is_wrap = 1'b0;
        end
        cont = (int'(len) + 1) * int'(bytes);
        cmask = cont - 1;
        a = addr;
        aw_bad = 1'b0;

        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        if (!awready) begin check("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
        @(posedge clk);
        n = 0;
        @(negedge clk);
        awvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            aw_bad |= awready;
            if (b == gap_beat) begin
                wvalid = 1'b0;
                repeat (gap_len) begin @(posedge clk); n++; @(negedge clk); aw_bad |= awready; end
            end
            idx = a >> 2;
            wvalid = 1'b1;
            wdata  = dq[b];
            wstrb  = sq[b];
            wlast  = (b == int'(len)) ^ (b == bad_last);
            if (idx < 32'd256) dbg_addr = idx[7:0];
            guard = 0;
            while (!wready && guard < 20) begin @(posedge clk); n++; @(negedge clk); guard++; end
            if (!wready) begin check("w_timeout", 32'd0, 32'd1); wvalid = 1'b0; return; end
            @(posedge clk);
            n++;
            old_ok = 1'b0;
            oldw = 32'd0;
            if (idx >= 32'd256) begin
                err = 1'b1;
            end else begin
                old_ok = ref_valid[idx];
                oldw = ref_mem[idx];
                for (int l = 0; l < 4; l++)
                    if (sq[b][l]) ref_mem[idx][8*l +: 8] = dq[b][8*l +: 8];
                if (sq[b] == 4'hF) ref_valid[idx] = 1'b1;
            end
            if (wlast != (b == int'(len))) err = 1'b1;
            if (b == abort_after) begin
                #1 rst = 1'b1;
                #1;
                check("rst_wready", {31'd0, wready}, 32'd0);
                check("rst_bvalid", {31'd0, bvalid}, 32'd0);
                check("rst_awready", {31'd0, awready}, 32'd1);
                wvalid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            wvalid = 1'b0;
            wlast = 1'b0;
            if (old_ok) check("dbg_prewrite", dbg_rdata, oldw);
            if (is_fixed) a = a;
            else if (is_wrap) a = (a & ~cmask) | ((a + bytes) & cmask);
            else a = a + bytes;
        end

        exp_resp = err ? 2'b10 : 2'b00;
        bready = (bdelay == 0);
        guard = 0;
        while (!bvalid && guard < 20) begin @(posedge clk); n++; @(negedge clk); guard++; end
        if (!bvalid) begin check("b_timeout", 32'd0, 32'd1); bready = 1'b0; return; end
        resp_seen = bresp;
        check("bid", {28'd0, bid}, {28'd0, id});
        check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        for (int d = 0; d < bdelay; d++) begin
            @(posedge clk); n++; @(negedge clk);
            aw_bad |= awready;
            check("b_hold_valid", {31'd0, bvalid}, 32'd1);
            check("b_hold_bid", {28'd0, bid}, {28'd0, id});
            check("b_hold_bresp", {30'd0, bresp}, {30'd0, exp_resp});
        end
        bready = 1'b1;
        @(posedge clk);
        n++;
        if (gap_len == 0 && bdelay == 0) check("b_latency", n, int'(len) + 2);
        @(negedge clk);
        bready = 1'b0;
        check("awready_blocked", {31'd0, aw_bad}, 32'd0);
        check("bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("awready_back", {31'd0, awready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] v, m2_old;
        int len_i;
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;

        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_bid", {28'd0, bid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_dbg", dbg_rdata, 32'd0);
        rst = 1'b0;

        // Fill the whole memory so later "unchanged" checks have known contents.
        for (int b = 0; b < 256; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd1, 32'h0, 8'd255, 3'd2, 2'b01, -1, -1, 0, 0, -1, r);
        check_all_mem();

        // INCR
        for (int b = 0; b < 4; b++) begin dq[b] = 32'hA0A0_0000 + b; sq[b] = 4'hF; end
        run_burst(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, -1, -1, 0, 0, -1, r);
        check("incr_bresp", {30'd0, r}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_read(4 + i, v);
            check("incr_mem", v, 32'hA0A0_0000 + i);
        end

        // WRAP
        for (int b = 0; b < 4; b++) begin dq[b] = 32'hD000_0000 + b; sq[b] = 4'hF; end
        run_burst(4'd2, 32'h18, 8'd3, 3'd2, 2'b10, -1, -1, 0, 0, -1, r);
        check("wrap_bresp", {30'd0, r}, 32'd0);
        dbg_read(6, v); check("wrap_mem6", v, 32'hD000_0000);
        dbg_read(7, v); check("wrap_mem7", v, 32'hD000_0001);
        dbg_read(4, v); check("wrap_mem4", v, 32'hD000_0002);
        dbg_read(5, v); check("wrap_mem5", v, 32'hD000_0003);

        // FIXED with narrow strobes
        m2_old = ref_mem[2];
        dq[0] = 32'h11; dq[1] = 32'h2200; dq[2] = 32'h330000;
        sq[0] = 4'h1;   sq[1] = 4'h2;     sq[2] = 4'h4;
        run_burst(4'd3, 32'h8, 8'd2, 3'd2, 2'b00, -1, -1, 0, 0, -1, r);
        check("fixed_bresp", {30'd0, r}, 32'd0);
        dbg_read(2, v);
        check("fixed_mem2", v, {m2_old[31:24], 24'h332211});

        // Backpressure: W gap of 2 cycles, bready held low for 3 cycles
        for (int b = 0; b < 4; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd9, 32'h40, 8'd3, 3'd2, 2'b01, -1, 2, 2, 3, -1, r);
        check("bp_bresp", {30'd0, r}, 32'd0);

        // Errors: early wlast, out-of-range index, then a clean burst
        for (int b = 0; b < 4; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd4, 32'h80, 8'd3, 3'd2, 2'b01, 1, -1, 0, 0, -1, r);
        check("err_wlast_bresp", {30'd0, r}, 32'd2);
        dq[0] = $urandom; sq[0] = 4'hF;
        run_burst(4'd6, 32'h400, 8'd0, 3'd2, 2'b01, -1, -1, 0, 0, -1, r);
        check("err_range_bresp", {30'd0, r}, 32'd2);
        for (int b = 0; b < 2; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd7, 32'h90, 8'd1, 3'd2, 2'b01, -1, -1, 0, 0, -1, r);
        check("err_clean_bresp", {30'd0, r}, 32'd0);

        // Reset mid-burst after beat 1
        for (int b = 0; b < 4; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd8, 32'h0, 8'd3, 3'd2, 2'b01, -1, -1, 0, 0, 1, r);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_bvalid", {31'd0, bvalid}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_read(i, v);
            check("abort_mem", v, ref_mem[i]);
        end
        for (int b = 0; b < 2; b++) begin dq[b] = $urandom; sq[b] = 4'hF; end
        run_burst(4'd10, 32'h20, 8'd1, 3'd2, 2'b01, -1, -1, 0, 0, -1, r);
        check("abort_next_bresp", {30'd0, r}, 32'd0);

        // Randomized bursts, including illegal size/burst/wrap length and out-of-range addresses
        for (int t = 0; t < 40; t++) begin
            len_i = $urandom_range(0, 15);
            for (int b = 0; b <= len_i; b++) begin dq[b] = $urandom; sq[b] = 4'($urandom); end
            run_burst(4'($urandom), 32'($urandom_range(0, 32'h47F)), 8'(len_i),
                      3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(0, len_i) : -1,
                      $urandom_range(0, len_i), $urandom_range(0, 2), $urandom_range(0, 3), -1, r);
        end
        check_all_mem();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
